rps_match_ctrl: RTL and testbench
=================================

# rps_match_ctrl

Sequential match controller for the rock-paper-scissors datapath: accepts one-hot moves from players A and B over independent valid/ready handshakes, judges each round, keeps per-player scores and declares the match winner at first-to-WIN_ROUNDS. It is the move-producing/round-sequencing end of the combinational round judge. It supplies registered, paired moves and consumes the judged outcome, so the top level gains a complete best-of-N game.

## Interface
- WIN_ROUNDS, 3, round wins needed to take the match (1..2^SCORE_W-1)
- SCORE_W, 4, width of score counters
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous and active-high
- start  in  1  begin a new match (sampled in IDLE and DONE only)
- a_valid  in  1  player A move offered
- a_move  in  3  A move, one-hot: 001 scissors, 010 rock, 100 paper
- a_ready  out  1  controller can take A's move
- b_valid  in  1  player B move offered
- b_move  in  3  B move, same encoding
- b_ready  out  1  controller can take B's move
- round_valid  out  1  one-cycle pulse, round judged
- round_result  out  2  00 tie, 01 A wins, 10 B wins, 11 never driven
- score_a  out  SCORE_W  A round wins this match
- score_b  out  SCORE_W  B round wins this match
- match_done  out  1  match finished, held until next start
- match_winner  out  1  0 = A, 1 = B; valid while match_done
- busy  out  1  high in COLLECT and EVAL

## Operation
- FSM states: IDLE, COLLECT, EVAL, DONE.
- IDLE: a_ready = b_ready = 0. start → COLLECT, scores cleared.
- COLLECT: a_ready high until A's move is captured; b_ready likewise, independently.
  - Capture on valid && ready.
  - A and B may be captured in the same cycle or in any order.
  - A second move from an already-captured player is not accepted (ready low).
  - When both are captured → EVAL.
- EVAL: lasts exactly one cycle.
  - Beats: scissors > paper, rock > scissors, paper > rock. Equal moves tie.
  - The winner's score increments; a tie changes neither score.
  - If the incremented score equals WIN_ROUNDS → DONE, else → COLLECT with capture flags cleared.
- DONE: match_done = 1; match_winner, scores and round_result hold. start → COLLECT with scores cleared.
- start in COLLECT or EVAL is ignored.
- Illegal move (not exactly one bit set) behaviour is set by Configuration.
- Scores never exceed WIN_ROUNDS, so no wrap-around occurs.

## Timing
- Reset values: a_ready = b_ready = 0, round_valid = 0, round_result = 00, score_a = score_b = 0, match_done = 0, match_winner = 0, busy = 0, state IDLE.
- rst mid-match aborts immediately: all of the above apply at the next edge and captured moves are discarded.
- All outputs are registered.
- start sampled at edge t: busy = 1 and ready outputs high from cycle t+1.
- Last capture at edge k: EVAL occupies cycle k+1.
  - round_valid, round_result and updated scores are visible in cycle k+2.
  - match_done and match_winner are also visible in cycle k+2 when the match ends.
- Ready re-asserts in cycle k+2 for a continuing match. Minimum round period is 2 cycles.
- round_valid is high for exactly 1 cycle per round.

## Configuration
- RPS_FORFEIT_EN defined:
  - An illegal move is captured normally and the round is judged as a forfeit.
  - Illegal A with legal B → B wins (10); legal A with illegal B → A wins (01); both illegal → tie (00).
- RPS_FORFEIT_EN undefined:
  - An illegal move completes the handshake (ready stays high) but is discarded.
  - That player remains uncaptured, ready stays high, and the round waits for a legal move.

## Test plan
- Reset/idle: rst = 1 for 2 cycles, then a_valid = b_valid = 1 with no start → both readys 0, all outputs at reset values, no round_valid.
- Simultaneous moves: start, then a_move = 010 and b_move = 001 in the same cycle → round_valid pulse 2 cycles later, round_result = 01, score_a = 1, score_b = 0.
- Staggered moves and tie: A sends 100, B sends 100 three cycles later → a_ready low while waiting, round_result = 00, scores unchanged.
- Full match (WIN_ROUNDS = 3): B wins three rounds (B: 100 vs A: 010) with one A win interleaved → match_done = 1, match_winner = 1, score_a = 1, score_b = 3. A later start clears scores and busy = 1.
- Illegal move: a_move = 011, b_move = 001.
  - With RPS_FORFEIT_EN → round_result = 10.
  - Without it → no round_valid until A sends 010, then round_result = 01.
- Reset mid-round: A captured, B pending, rst pulsed → IDLE, scores 0, a later start begins a clean round needing both moves.

Source files
------------

// File: rtl/rps_match_ctrl.sv
// Best-of-N rock-paper-scissors match controller: pairs A/B moves, judges rounds, keeps scores.
// Define RPS_FORFEIT_EN to judge illegal (non-one-hot) moves as forfeits instead of discarding them.
module rps_match_ctrl #(
  parameter int unsigned WIN_ROUNDS = 3,
  parameter int unsigned SCORE_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               a_valid,
  input  logic [2:0]         a_move,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [2:0]         b_move,
  output logic               b_ready,
  output logic               round_valid,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               match_done,
  output logic               match_winner,
  output logic               busy
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StEval    = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  localparam logic [1:0] ResTie  = 2'b00;
  localparam logic [1:0] ResAWin = 2'b01;
  localparam logic [1:0] ResBWin = 2'b10;

  localparam logic [SCORE_W-1:0] WinCnt = SCORE_W'(WIN_ROUNDS);

  logic [1:0]         stateQ, stateD;
  logic               aCapQ, aCapD, bCapQ, bCapD;
  logic [2:0]         aMoveQ, aMoveD, bMoveQ, bMoveD;
  logic [SCORE_W-1:0] scoreAQ, scoreAD, scoreBQ, scoreBD;
  logic               roundValidQ, roundValidD;
  logic [1:0]         roundResultQ, roundResultD;
  logic               matchDoneQ, matchDoneD;
  logic               matchWinnerQ, matchWinnerD;
  logic               aReadyQ, aReadyD, bReadyQ, bReadyD;
  logic               busyQ, busyD;
  logic               aAccept, bAccept;
  logic [1:0]         res;

  function automatic logic isLegal(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
  endfunction

  // 001 scissors, 010 rock, 100 paper
  function automatic logic [1:0] judge(input logic [2:0] a, input logic [2:0] b);
    logic aBeats;
`ifdef RPS_FORFEIT_EN
    if (!isLegal(a) && !isLegal(b)) return ResTie;
    if (!isLegal(a)) return ResBWin;
    if (!isLegal(b)) return ResAWin;
`endif
    if (a == b) return ResTie;
    aBeats = (a == 3'b001 && b == 3'b100) || (a == 3'b010 && b == 3'b001) ||
             (a == 3'b100 && b == 3'b010);
    return aBeats ? ResAWin : ResBWin;
  endfunction

  always_comb begin
    stateD       = stateQ;
    aCapD        = aCapQ;
    bCapD        = bCapQ;
    aMoveD       = aMoveQ;
    bMoveD       = bMoveQ;
    scoreAD      = scoreAQ;
    scoreBD      = scoreBQ;
    roundValidD  = 1'b0;
    roundResultD = roundResultQ;
    matchDoneD   = matchDoneQ;
    matchWinnerD = matchWinnerQ;
    aAccept      = 1'b0;
    bAccept      = 1'b0;
    res          = ResTie;

    unique case (stateQ)
      StIdle, StDone: begin
        if (start) begin
          stateD       = StCollect;
          aCapD        = 1'b0;
          bCapD        = 1'b0;
          scoreAD      = '0;
          scoreBD      = '0;
          matchDoneD   = 1'b0;
          matchWinnerD = 1'b0;
        end
      end
      StCollect: begin
`ifdef RPS_FORFEIT_EN
        aAccept = a_valid && aReadyQ;
        bAccept = b_valid && bReadyQ;
`else
        // Illegal moves complete the handshake but leave the player uncaptured.
        aAccept = a_valid && aReadyQ && isLegal(a_move);
        bAccept = b_valid && bReadyQ && isLegal(b_move);
`endif
        if (aAccept) begin
          aCapD  = 1'b1;
          aMoveD = a_move;
        end
        if (bAccept) begin
          bCapD  = 1'b1;
          bMoveD = b_move;
        end
        if (aCapD && bCapD) stateD = StEval;
      end
      StEval: begin
        res          = judge(aMoveQ, bMoveQ);
        roundValidD  = 1'b1;
        roundResultD = res;
        aCapD        = 1'b0;
        bCapD        = 1'b0;
        stateD       = StCollect;
        if (res == ResAWin) begin
          scoreAD = scoreAQ + SCORE_W'(1);
          if (scoreAD == WinCnt) begin
            stateD       = StDone;
            matchDoneD   = 1'b1;
            matchWinnerD = 1'b0;
          end
        end else if (res == ResBWin) begin
          scoreBD = scoreBQ + SCORE_W'(1);
          if (scoreBD == WinCnt) begin
            stateD       = StDone;
            matchDoneD   = 1'b1;
            matchWinnerD = 1'b1;
          end
        end
      end
      default: stateD = StIdle;
    endcase

    // Decoded from next-state so every output comes straight from a flop.
    aReadyD = (stateD == StCollect) && !aCapD;
    bReadyD = (stateD == StCollect) && !bCapD;
    busyD   = (stateD == StCollect) || (stateD == StEval);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ       <= StIdle;
      aCapQ        <= 1'b0;
      bCapQ        <= 1'b0;
      aMoveQ       <= 3'b000;
      bMoveQ       <= 3'b000;
      scoreAQ      <= '0;
      scoreBQ      <= '0;
      roundValidQ  <= 1'b0;
      roundResultQ <= ResTie;
      matchDoneQ   <= 1'b0;
      matchWinnerQ <= 1'b0;
      aReadyQ      <= 1'b0;
      bReadyQ      <= 1'b0;
      busyQ        <= 1'b0;
    end else begin
      stateQ       <= stateD;
      aCapQ        <= aCapD;
      bCapQ        <= bCapD;
      aMoveQ       <= aMoveD;
      bMoveQ       <= bMoveD;
      scoreAQ      <= scoreAD;
      scoreBQ      <= scoreBD;
      roundValidQ  <= roundValidD;
      roundResultQ <= roundResultD;
      matchDoneQ   <= matchDoneD;
      matchWinnerQ <= matchWinnerD;
      aReadyQ      <= aReadyD;
      bReadyQ      <= bReadyD;
      busyQ        <= busyD;
    end
  end

  assign a_ready      = aReadyQ;
  assign b_ready      = bReadyQ;
  assign round_valid  = roundValidQ;
  assign round_result = roundResultQ;
  assign score_a      = scoreAQ;
  assign score_b      = scoreBQ;
  assign match_done   = matchDoneQ;
  assign match_winner = matchWinnerQ;
  assign busy         = busyQ;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Table-driven bench for rps_match_ctrl; expectations follow RPS_FORFEIT_EN when defined.
module tb_rps_match_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, a_valid, b_valid;
  logic [2:0] a_move, b_move;
  logic       a_ready, b_ready, round_valid, match_done, match_winner, busy;
  logic [1:0] round_result;
  logic [3:0] score_a, score_b;

  rps_match_ctrl #(.WIN_ROUNDS(3), .SCORE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_valid(a_valid), .a_move(a_move), .a_ready(a_ready),
    .b_valid(b_valid), .b_move(b_move), .b_ready(b_ready),
    .round_valid(round_valid), .round_result(round_result),
    .score_a(score_a), .score_b(score_b),
    .match_done(match_done), .match_winner(match_winner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        av;
    logic [2:0]  am;
    logic        bv;
    logic [2:0]  bm;
    logic [15:0] exp;
  } vec_t;

  vec_t vq[$];
  int   nVec = 0;
  int   nErr = 0;

  // Layout: {a_ready, b_ready, round_valid, round_result, score_a, score_b, done, winner, busy}
  function automatic logic [15:0] pk(input logic ar, input logic br, input logic rv,
                                     input logic [1:0] rr, input logic [3:0] sa,
                                     input logic [3:0] sb, input logic md, input logic mw,
                                     input logic bz);
    return {ar, br, rv, rr, sa, sb, md, mw, bz};
  endfunction

  function automatic logic [15:0] actual();
    return {a_ready, b_ready, round_valid, round_result, score_a, score_b, match_done,
            match_winner, busy};
  endfunction

  task automatic addV(input logic st, input logic av, input logic [2:0] am, input logic bv,
                      input logic [2:0] bm, input logic [15:0] exp);
    vec_t v;
    v.st = st; v.av = av; v.am = am; v.bv = bv; v.bm = bm; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic drive(input logic st, input logic av, input logic [2:0] am, input logic bv,
                       input logic [2:0] bm);
    @(negedge clk);
    start = st; a_valid = av; a_move = am; b_valid = bv; b_move = bm;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = actual();
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got {ar,br,rv,rr,sa,sb,md,mw,bz}=%b_%b_%b_%b_%0d_%0d_%b_%b_%b, required %b_%b_%b_%b_%0d_%0d_%b_%b_%b",
               name, act[15], act[14], act[13], act[12:11], act[10:7], act[6:3], act[2],
               act[1], act[0], exp[15], exp[14], exp[13], exp[12:11], exp[10:7], exp[6:3],
               exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_move = 3'b0; b_move = 3'b0;

    // Idle: moves offered without start are ignored
    addV(0, 1, 3'b010, 1, 3'b001, pk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    addV(1, 0, 3'b000, 0, 3'b000, pk(1, 1, 0, 2'b00, 0, 0, 0, 0, 1));
    // Simultaneous: rock vs scissors -> A wins two cycles after capture
    addV(0, 1, 3'b010, 1, 3'b001, pk(0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
    addV(0, 0, 3'b000, 0, 3'b000, pk(1, 1, 1, 2'b01, 1, 0, 0, 0, 1));
    // Staggered tie: paper vs paper, B three cycles late
    addV(0, 1, 3'b100, 0, 3'b000, pk(0, 1, 0, 2'b01, 1, 0, 0, 0, 1));
    addV(0, 1, 3'b100, 0, 3'b000, pk(0, 1, 0, 2'b01, 1, 0, 0, 0, 1));
    addV(0, 0, 3'b000, 0, 3'b000, pk(0, 1, 0, 2'b01, 1, 0, 0, 0, 1));
    addV(0, 0, 3'b000, 1, 3'b100, pk(0, 0, 0, 2'b01, 1, 0, 0, 0, 1));
    addV(0, 0, 3'b000, 0, 3'b000, pk(1, 1, 1, 2'b00, 1, 0, 0, 0, 1));
    // Three B wins: paper beats rock
    addV(0, 1, 3'b010, 1, 3'b100, pk(0, 0, 0, 2'b00, 1, 0, 0, 0, 1));
    addV(0, 0, 3'b000, 0, 3'b000, pk(1, 1, 1, 2'b10, 1, 1, 0, 0, 1));
    addV(0, 1, 3'b010, 1, 3'b100, pk(0, 0, 0, 2'b10, 1, 1, 0, 0, 1));
    addV(0, 0, 3'b000, 0, 3'b000, pk(1, 1, 1, 2'b10, 1, 2, 0, 0, 1));
    addV(0, 1, 3'b010, 1, 3'b100, pk(0, 0, 0, 2'b10, 1, 2, 0, 0, 1));
    addV(0, 0, 3'b000, 0, 3'b000, pk(0, 0, 1, 2'b10, 1, 3, 1, 1, 0));
    // Done holds while moves are offered
    addV(0, 1, 3'b010, 1, 3'b100, pk(0, 0, 0, 2'b10, 1, 3, 1, 1, 0));
    // Restart clears scores
    addV(1, 0, 3'b000, 0, 3'b000, pk(1, 1, 0, 2'b10, 0, 0, 0, 0, 1));
    // start in COLLECT and EVAL is ignored; rock beats scissors for B
    addV(1, 1, 3'b001, 0, 3'b000, pk(0, 1, 0, 2'b10, 0, 0, 0, 0, 1));
    addV(0, 0, 3'b000, 1, 3'b010, pk(0, 0, 0, 2'b10, 0, 0, 0, 0, 1));
    addV(1, 0, 3'b000, 0, 3'b000, pk(1, 1, 1, 2'b10, 0, 1, 0, 0, 1));
    // Illegal A move 011 against scissors
`ifdef RPS_FORFEIT_EN
    addV(0, 1, 3'b011, 1, 3'b001, pk(0, 0, 0, 2'b10, 0, 1, 0, 0, 1));
    addV(0, 0, 3'b000, 0, 3'b000, pk(1, 1, 1, 2'b10, 0, 2, 0, 0, 1));
    addV(0, 1, 3'b010, 0, 3'b000, pk(0, 1, 0, 2'b10, 0, 2, 0, 0, 1));
    addV(0, 0, 3'b000, 0, 3'b000, pk(0, 1, 0, 2'b10, 0, 2, 0, 0, 1));
`else
    addV(0, 1, 3'b011, 1, 3'b001, pk(1, 0, 0, 2'b10, 0, 1, 0, 0, 1));
    addV(0, 0, 3'b000, 0, 3'b000, pk(1, 0, 0, 2'b10, 0, 1, 0, 0, 1));
    addV(0, 1, 3'b010, 0, 3'b000, pk(0, 0, 0, 2'b10, 0, 1, 0, 0, 1));
    addV(0, 0, 3'b000, 0, 3'b000, pk(1, 1, 1, 2'b01, 1, 1, 0, 0, 1));
`endif

    drive(0, 0, 3'b000, 0, 3'b000);
    drive(0, 0, 3'b000, 0, 3'b000);
    check("reset", pk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].st, vq[i].av, vq[i].am, vq[i].bv, vq[i].bm);
      check($sformatf("vec%0d", i), vq[i].exp);
    end

    // Reset mid-round: A captured, B pending
    drive(0, 1, 3'b100, 0, 3'b000);
    rst = 1'b1;
    drive(0, 0, 3'b000, 0, 3'b000);
    check("midReset", pk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    rst = 1'b0;
    drive(1, 0, 3'b000, 0, 3'b000);
    check("restart", pk(1, 1, 0, 2'b00, 0, 0, 0, 0, 1));
    drive(0, 1, 3'b010, 0, 3'b000);
    check("aOnly", pk(0, 1, 0, 2'b00, 0, 0, 0, 0, 1));
    drive(0, 0, 3'b000, 0, 3'b000);
    check("bPending", pk(0, 1, 0, 2'b00, 0, 0, 0, 0, 1));
    drive(0, 0, 3'b000, 1, 3'b100);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 3'b000, 0, 3'b000);
      if (round_valid) break;
    end
    if (!round_valid) begin
      nVec++;
      nErr++;
      $display("FAIL roundTimeout: got round_valid=0 after 4 cycles, required 1");
    end else begin
      check("cleanRound", pk(1, 1, 1, 2'b10, 0, 1, 0, 0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
